// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential reverse double-dabble BCD-to-binary converter with start/busy/done handshake
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W = 14
) (
  input  logic                clk,
  input  logic                reset_p,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd,
  output logic [BIN_W-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bcd_reg, bcd_reg_n, bcd_s;
  logic [BIN_W-1:0] bin_reg, bin_reg_n, bin_s, bin_n;
  logic busy_n, done_n, err_n, bad;
  // one shift-right step with per-nibble minus-3 correction, plus operand digit check
  always_comb begin
    bcd_s = bcd_reg >> 1;
    bin_s = {bcd_reg[0], bin_reg[BIN_W-1:1]};
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_s[4*i+:4] = bcd_s[4*i+3] ? bcd_s[4*i+:4] - 4'd3 : bcd_s[4*i+:4];
      bad = bad | (bcd[4*i+:4] > 4'd9);
    end
  end
  // next-state and output decode
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bcd_reg_n = bcd_reg;
    bin_reg_n = bin_reg;
    bin_n = bin;
    busy_n = busy;
    done_n = 1'b0;
    err_n = err;
    if (state == IDLE) begin
      if (start && !bad) begin
        bcd_reg_n = bcd;
        bin_reg_n = '0;
        err_n = 1'b0;
        busy_n = 1'b1;
        cnt_n = '0;
        state_n = SHIFT;
      end else if (start) begin
        bin_n = '0;
        err_n = 1'b1;
        done_n = 1'b1;
      end
    end else begin
      bcd_reg_n = bcd_s;
      bin_reg_n = bin_s;
      cnt_n = cnt + 1'b1;
      if (cnt == CW'(BIN_W - 1)) begin
        bin_n = bin_s;
        done_n = 1'b1;
        busy_n = 1'b0;
        state_n = IDLE;
      end
    end
  end
  // state and output registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state <= IDLE;
      cnt <= '0;
      bcd_reg <= '0;
      bin_reg <= '0;
      bin <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bcd_reg <= bcd_reg_n;
      bin_reg <= bin_reg_n;
      bin <= bin_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
    end
  end
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and random checks of bcd_to_bin_seq against a decimal reference model
module tb_bcd_to_bin_seq;
  localparam int BIN_W = 14;
  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic start = 1'b0;
  logic [15:0] bcd = '0;
  logic [BIN_W-1:0] bin;
  logic busy, done, err;
  int passed = 0;
  int total = 0;
  logic [31:0] last_bin = 0;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(BIN_W)) dut (
    .clk(clk), .reset_p(reset_p), .start(start), .bcd(bcd),
    .bin(bin), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic is_valid(input logic [15:0] v);
    for (int i = 0; i < 4; i++)
      if (((v >> (4 * i)) & 16'hF) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] dec_value(input logic [15:0] v);
    int s = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      s += int'((v >> (4 * i)) & 16'hF) * w;
      w *= 10;
    end
    return 32'(s);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Accepts v at the next edge; returns just after the done edge (done visible).
  // poke>0 pulses an ignored start with 0007 during the conversion at that cycle.
  task automatic conv(input logic [15:0] v, input int poke);
    logic [31:0] exp;
    bcd = v;
    start = 1'b1;
    step();
    start = 1'b0;
    bcd = 16'($urandom);
    if (!is_valid(v)) begin
      check("inv_done", 32'(done), 1);
      check("inv_err", 32'(err), 1);
      check("inv_bin", 32'(bin), 0);
      check("inv_busy", 32'(busy), 0);
      last_bin = 0;
      return;
    end
    exp = dec_value(v);
    check("acc_busy", 32'(busy), 1);
    check("acc_err", 32'(err), 0);
    check("acc_done", 32'(done), 0);
    check("acc_bin_hold", 32'(bin), last_bin);
    for (int c = 1; c < BIN_W; c++) begin
      start = (c == poke);
      bcd = (c == poke) ? 16'h0007 : 16'($urandom);
      step();
      check("run_busy", 32'(busy), 1);
      check("run_done", 32'(done), 0);
      check("run_bin_hold", 32'(bin), last_bin);
    end
    start = 1'b0;
    step();
    check("fin_done", 32'(done), 1);
    check("fin_busy", 32'(busy), 0);
    check("fin_err", 32'(err), 0);
    check("fin_bin", 32'(bin), exp);
    last_bin = exp;
  endtask

  task automatic idle_check();
    step();
    check("done_drop", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_bin_hold", 32'(bin), last_bin);
  endtask

  initial begin
    int saw_done;
    logic [15:0] v;
    step();
    step();
    check("rst_bin", 32'(bin), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    reset_p = 1'b0;
    step();
    conv(16'h1234, 0);
    idle_check();
    conv(16'h9999, 0);
    idle_check();
    conv(16'h0000, 0);
    idle_check();
    conv(16'h12A4, 0);
    idle_check();
    check("err_hold", 32'(err), 1);
    conv(16'h0042, 0);
    idle_check();
    conv(16'h0500, 5);
    idle_check();
    conv(16'h0321, 0);
    conv(16'h0123, 0);
    idle_check();
    conv(16'hF000, 0);
    conv(16'h0777, 0);
    idle_check();
    bcd = 16'h8765;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    reset_p = 1'b1;
    #1;
    check("mid_rst_bin", 32'(bin), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_err", 32'(err), 0);
    last_bin = 0;
    step();
    #2;
    reset_p = 1'b0;
    saw_done = 0;
    repeat (20) begin
      step();
      saw_done += int'(done) + int'(busy);
    end
    check("no_done_after_rst", 32'(saw_done), 0);
    conv(16'h8765, 0);
    idle_check();
    for (int n = 0; n < 24; n++) begin
      v = 16'($urandom);
      if ($urandom_range(0, 3) != 0)
        for (int d = 0; d < 4; d++) v[4*d+:4] = 4'($urandom_range(0, 9));
      conv(v, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, BIN_W - 1)) : 0);
      if ($urandom_range(0, 1) == 1) idle_check();
    end
    idle_check();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter using the reverse double-dabble algorithm, one shift per clock. It is the decode-side partner of the combinational binary-to-BCD converter. It takes a packed multi-digit BCD value, for example from keypad or digit-entry logic, and returns its binary equivalent. A start/busy/done handshake lets it feed arithmetic and comparator blocks downstream.

## Interface
- DIGITS, 4: number of BCD digits in the input; input width is 4*DIGITS.
- BIN_W, 14: result width. Must satisfy 2^BIN_W > 10^DIGITS − 1; the default holds 0..9999.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_p  input  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- start  input  1  conversion request, sampled on the rising edge.
- bcd  input  4*DIGITS  packed BCD operand; digit 0 is in [3:0]. Sampled only on the edge that accepts start.
- bin  output  BIN_W  binary result, registered.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bin/err become valid.
- err  output  1  high when the accepted operand had a digit greater than 9.

## Operation
- Reset values: bin=0, busy=0, done=0, err=0, FSM=IDLE, shift count=0.
- Working register: {bcd_reg[4*DIGITS-1:0], bin_reg[BIN_W-1:0]}.
- FSM states: IDLE and SHIFT.
- IDLE, start=1, all digits ≤ 9:
  - load bcd_reg=bcd and bin_reg=0;
  - clear err; set busy=1; count=0; go to SHIFT.
- IDLE, start=1, any digit > 9:
  - no conversion; bin=0, err=1, done=1 for one cycle;
  - busy stays 0; stay in IDLE.
- SHIFT, each edge, one step:
  - shift the working register right by 1; bcd_reg[0] enters bin_reg[BIN_W-1];
  - then, on the post-shift value, subtract 3 from each bcd_reg nibble that is ≥ 8;
  - count increments.
- SHIFT exit: on the BIN_W-th step, bin takes the final bin_reg, done=1, busy=0, return to IDLE. bcd_reg is all-zero at that point for any valid operand.
- bin and err hold their values until the next accepted start. An accepted valid start clears err immediately. bin keeps its old value until the new result is written.
- Arithmetic: the nibble correction is a 4-bit unsigned subtract with no borrow between nibbles, since every corrected nibble is ≥ 8. Result range is 0 to 10^DIGITS − 1; no overflow is possible under the BIN_W constraint.

## Timing
- Let E0 be the edge that samples start=1 in IDLE.
- Valid operand:
  - busy is high in the cycles after E0 through E(BIN_W).
  - Shifts occur on E1..E(BIN_W).
  - done and the new bin are visible after E(BIN_W); done drops after E(BIN_W+1).
  - Latency is BIN_W cycles (14 by default).
- Invalid operand: done and err are visible after E0 (latency 1).
- start while busy=1 is ignored. No queuing; bcd is not sampled.
- start=1 in the done cycle is accepted, since the FSM is already in IDLE. Back-to-back throughput is one result per BIN_W+1 cycles.
- start held high: a new conversion begins on every edge where the FSM is in IDLE.
- bcd changes while busy have no effect.
- reset_p asserted mid-conversion: all outputs and state return to reset values immediately, without waiting for a clock. No done pulse is issued. The first start after reset_p is released is accepted normally.

## Test plan
- Reset, then bcd=16'h1234 with a one-cycle start → busy high for 14 cycles, then done pulse with bin=14'd1234 (0x4D2), err=0.
- bcd=16'h9999 and bcd=16'h0000 → bin=9999 (0x270F) and bin=0 respectively, each after exactly 14 cycles.
- bcd=16'h12A4 with start → done one cycle after acceptance, err=1, bin=0, busy never asserted. A following start with 16'h0042 → err clears on acceptance, and bin=42.
- Start with 16'h0500, then pulse start again with 16'h0007 at cycle 5 → the second start is ignored; result is 500 at cycle 14.
- Start with 16'h0321, then start with 16'h0123 asserted in the done cycle → bin=321 on the first done pulse and 123 on the second, 15 cycles later.
- Start with 16'h8765, assert reset_p at cycle 7 → bin=0, busy=0, done=0 immediately; no done pulse follows. A fresh start with 16'h8765 → bin=8765.
